// File: rtl/uart_dac_writer_pkg.sv
// Shared types and helpers for the UART-to-DAC frame writer.
// Optional inter-byte timeout is enabled with UART_DAC_WRITER_TIMEOUT_EN.
package uart_dac_writer_pkg;

    localparam int DEFAULT_SIZE = 32;
    localparam int SAMPLE_W     = 12;
    localparam int COUNTER_W    = 20;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        PLAY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_e;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_dac_writer_if.sv
// Host/CPU-facing signal bundle of uart_dac_writer: control in, DAC bus and status out.
interface uart_dac_writer_if;
    import uart_dac_writer_pkg::*;

    logic                 start;
    logic [COUNTER_W-1:0] counter;
    logic                 rx;
    logic [SAMPLE_W-1:0]  data_da;
    logic                 da_valid;
    logic                 ready;
    logic                 frame_err;

    modport master (
        output start, counter, rx,
        input  data_da, da_valid, ready, frame_err
    );

    modport slave (
        input  start, counter, rx,
        output data_da, da_valid, ready, frame_err
    );

endinterface

// File: rtl/uart_dac_writer_uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid/stop_err pulses.
module uart_rx_core
    import uart_dac_writer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       stop_err_o
);

    localparam int            TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_q;
    logic          rx_meta_q;
    logic          rx_sync_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          byte_valid_q;
    logic          stop_err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= R_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx_i;
            rx_sync_q    <= rx_meta_q;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            timer_q      <= timer_q + TW'(1);
            case (state_q)
                R_IDLE: begin
                    timer_q <= '0;
                    if (!rx_sync_q) state_q <= R_START;
                end
                R_START: begin
                    // Line must still be low half a bit later, otherwise it was a glitch.
                    if (timer_q == HALF_LAST) begin
                        timer_q   <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_sync_q ? R_IDLE : R_DATA;
                    end
                end
                R_DATA: begin
                    if (timer_q == FULL_LAST) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= R_STOP;
                    end
                end
                R_STOP: begin
                    if (timer_q == FULL_LAST) begin
                        timer_q <= '0;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            state_q      <= R_IDLE;
                        end else begin
                            stop_err_q <= 1'b1;
                            state_q    <= R_WAIT_HIGH;
                        end
                    end
                end
                R_WAIT_HIGH: begin
                    timer_q <= '0;
                    if (rx_sync_q) state_q <= R_IDLE;
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = byte_valid_q;
    assign stop_err_o   = stop_err_q;

endmodule

// File: rtl/uart_dac_writer.sv
// Receives a 2*SIZE-byte UART frame into SIZE 12-bit samples and replays them on the DAC bus.
// Define UART_DAC_WRITER_TIMEOUT_EN to abort reception after TIMEOUT_BITS idle bit times.
module uart_dac_writer
    import uart_dac_writer_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int SIZE         = DEFAULT_SIZE,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               sysclk,
    input  logic               rst,
    uart_dac_writer_if.slave   dac_bus
);

    localparam int             CPB    = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int             J_W    = $clog2(2 * SIZE);
    localparam int             K_W    = $clog2(SIZE);
    localparam logic [J_W-1:0] J_LAST = J_W'(2 * SIZE - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(SIZE - 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       stop_err;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk_i        (sysclk),
        .rst_i        (rst),
        .rx_i         (dac_bus.rx),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .stop_err_o   (stop_err)
    );

    state_e               state_q;
    logic [J_W-1:0]       j_q;
    logic [K_W-1:0]       k_q;
    logic [7:0]           low_q;
    logic [COUNTER_W-1:0] tick_q;
    logic [COUNTER_W-1:0] period_q;
    logic [SAMPLE_W-1:0]  data_da_q;
    logic                 da_valid_q;
    logic                 ready_q;
    logic                 frame_err_q;
    logic [SAMPLE_W-1:0]  samples_q [SIZE];

    logic                 word_we;
    logic                 pad_err;
    logic [COUNTER_W-1:0] period_d;
    logic                 timeout;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        word_we  = (state_q == RECV) && dac_bus.start && byte_valid && j_q[0];
        pad_err  = (rx_byte[7:4] != 4'd0);
        period_d = (dac_bus.counter == '0) ? COUNTER_W'(1) : dac_bus.counter;
    end

`ifdef UART_DAC_WRITER_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CPB;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] idle_q;
    logic            armed_q;

    // Idle counter only runs once the first byte of the frame has arrived.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            idle_q  <= '0;
            armed_q <= 1'b0;
        end else if (state_q != RECV) begin
            idle_q  <= '0;
            armed_q <= 1'b0;
        end else if (byte_valid) begin
            idle_q  <= '0;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            idle_q <= idle_q + TO_W'(1);
        end
    end

    assign timeout = armed_q && !byte_valid && (idle_q == TO_W'(TO_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: the sample buffer has no reset; it is always written before it is played.
    always_ff @(posedge sysclk) begin
        if (word_we) samples_q[j_q[J_W-1:1]] <= {rx_byte[3:0], low_q};
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            j_q         <= '0;
            k_q         <= '0;
            low_q       <= '0;
            tick_q      <= '0;
            period_q    <= COUNTER_W'(1);
            data_da_q   <= '0;
            da_valid_q  <= 1'b0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            da_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    j_q         <= '0;
                    k_q         <= '0;
                    frame_err_q <= 1'b0;
                    ready_q     <= 1'b0;
                    if (dac_bus.start) state_q <= RECV;
                end
                RECV: begin
                    if (!dac_bus.start) begin
                        state_q <= IDLE;
                    end else if (timeout) begin
                        frame_err_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        if (stop_err) frame_err_q <= 1'b1;
                        if (byte_valid) begin
                            j_q <= j_q + J_W'(1);
                            if (!j_q[0])     low_q       <= rx_byte;
                            else if (pad_err) frame_err_q <= 1'b1;
                            if (j_q == J_LAST) begin
                                state_q  <= PLAY;
                                k_q      <= '0;
                                tick_q   <= '0;
                                period_q <= period_d;
                            end
                        end
                    end
                end
                PLAY: begin
                    if (!dac_bus.start) begin
                        state_q <= IDLE;
                    end else if (tick_q == period_q - COUNTER_W'(1)) begin
                        // Period is re-sampled on every wrap so changes apply to the next sample.
                        tick_q     <= '0;
                        period_q   <= period_d;
                        data_da_q  <= samples_q[k_q];
                        da_valid_q <= 1'b1;
                        k_q        <= k_q + K_W'(1);
                        if (k_q == K_LAST) state_q <= DONE;
                    end else begin
                        tick_q <= tick_q + COUNTER_W'(1);
                    end
                end
                DONE: begin
                    if (!dac_bus.start) begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dac_bus.data_da   = data_da_q;
    assign dac_bus.da_valid  = da_valid_q;
    assign dac_bus.ready     = ready_q;
    assign dac_bus.frame_err = frame_err_q;

endmodule
